// File: rtl/lsu_wb.sv
`default_nettype none
// ============================================================================
// lsu_wb : load/store unit that maps byte/half/word core requests onto
//          word-aligned Wishbone cycles (sub-word stores via read-modify-write).
//          Optional ACK watchdog: define LSU_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module lsu_wb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  output logic [ADDR_WIDTH-1:0] wb_adr,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_GAP   = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [1:0]              lane_q, lane_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [31:0]             dat_o_q, dat_o_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    cyc_q, cyc_d;
  logic                    wbwe_q, wbwe_d;
  logic                    valid_q, valid_d;
  logic                    misaligned;
  logic                    timeout;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] ln, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{ln, 3'b000} +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    case (sz)
      2'd0:    load_ext = {{24{~uns & b[7]}}, b};
      2'd1:    load_ext = {{16{~uns & h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] sz, input logic [1:0] ln);
    logic [31:0] r;
    r = w;
    if (sz == 2'd0)
      r[{ln, 3'b000} +: 8] = d[7:0];
    else if (sz == 2'd1)
      r[{ln[1], 4'b0000} +: 16] = d[15:0];
    else
      r = d;
    return r;
  endfunction

  assign misaligned = (req_size == 2'd3) ||
                      (req_size == 2'd1 && req_addr[0]) ||
                      (req_size == 2'd2 && req_addr[1:0] != 2'b00);

`ifdef LSU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q, tmr_d;

  // Counter restarts whenever a bus state is (re)entered, including GAP->WRITE.
  always_comb begin
    tmr_d = '0;
    if ((state_q == S_READ || state_q == S_WRITE) && state_d == state_q)
      tmr_d = tmr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) tmr_q <= '0;
    else     tmr_q <= tmr_d;
  end

  assign timeout = (tmr_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    adr_d   = adr_q;
    dat_o_d = dat_o_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata;
          adr_d   = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          if (misaligned) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (!req_we || req_size != 2'd2) begin
            state_d = S_READ;
          end else begin
            state_d = S_WRITE;
            dat_o_d = req_wdata;
          end
        end
      end
      S_READ: begin
        if (wb_ack) begin
          if (!we_q) begin
            state_d = S_RESP;
            rdata_d = load_ext(wb_dat_i, size_q, lane_q, uns_q);
          end else begin
            state_d = S_GAP;
            dat_o_d = merge(wb_dat_i, wdata_q, size_q, lane_q);
          end
        end else if (timeout) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      // Lets the slave's registered ACK from the read drain with CYC low.
      S_GAP:   state_d = S_WRITE;
      S_WRITE: begin
        if (wb_ack) begin
          state_d = S_RESP;
          rdata_d = '0;
        end else if (timeout) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    cyc_d   = (state_d == S_READ) || (state_d == S_WRITE);
    wbwe_d  = (state_d == S_WRITE);
    valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      lane_q  <= 2'd0;
      wdata_q <= '0;
      adr_q   <= '0;
      dat_o_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      wbwe_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      adr_q   <= adr_d;
      dat_o_q <= dat_o_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      wbwe_q  <= wbwe_d;
      valid_q <= valid_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign wb_cyc     = cyc_q;
  assign wb_stb     = cyc_q;
  assign wb_we      = wbwe_q;
  assign wb_adr     = adr_q;
  assign wb_dat_o   = dat_o_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_wb.sv
`default_nettype none
// ============================================================================
// tb_lsu_wb : directed self-checking bench for lsu_wb with a registered-ACK
//             Wishbone RAM model.
// Revision: 1.0
// ============================================================================
module tb_lsu_wb;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack;

  lsu_wb #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .wb_cyc       (wb_cyc),
    .wb_stb       (wb_stb),
    .wb_we        (wb_we),
    .wb_adr       (wb_adr),
    .wb_dat_o     (wb_dat_o),
    .wb_dat_i     (wb_dat_i),
    .wb_ack       (wb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM slave: ACK and read data registered from CYC&STB, no byte selects.
  logic [31:0] mem [0:255];
  logic        silent;
  logic        pre_en;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;

  always @(posedge clk) begin
    if (rst) wb_ack <= 1'b0;
    else     wb_ack <= wb_cyc & wb_stb & ~silent;
    wb_dat_i <= mem[wb_adr[9:2]];
    if (pre_en)
      mem[pre_idx] <= pre_val;
    else if (wb_cyc && wb_stb && wb_we)
      mem[wb_adr[9:2]] <= wb_dat_o;
  end

  int          cyc_cnt  = 0;
  int          resp_cnt = 0;
  int          viol     = 0;
  logic        prev_acc = 1'b0;
  logic [31:0] rd_adr   = '0;
  logic [31:0] wr_adr   = '0;
  logic [31:0] wr_dat   = '0;

  always @(negedge clk) begin
    if (wb_cyc) cyc_cnt++;
    if (wb_cyc && wb_stb && !wb_we) rd_adr = wb_adr;
    if (wb_cyc && wb_stb && wb_we) begin
      wr_adr = wb_adr;
      wr_dat = wb_dat_o;
    end
    if (prev_acc && wb_cyc) viol++;
    prev_acc = wb_cyc && wb_ack;
    if (resp_valid) resp_cnt++;
  end

  int n_cmp    = 0;
  int n_err    = 0;
  int exp_resp = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = a[9:2];
    pre_val = v;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  // Issues one request; lat counts cycles from the handshake cycle (0) to resp_valid.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int cycs);
    int c0;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = a;
    req_wdata    = wd;
    c0           = cyc_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    lat       = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd   = resp_rdata;
    er   = resp_err;
    cycs = cyc_cnt - c0;
    exp_resp++;
  endtask

  int          lat;
  int          cycs;
  logic [31:0] rd;
  logic        er;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; silent = 1'b0; pre_en = 1'b0; pre_idx = '0; pre_val = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_cyc",   {31'd0, wb_cyc},     32'd0);
    check_eq("rst_we",    {31'd0, wb_we},      32'd0);
    check_eq("rst_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("rst_adr",   wb_adr,              32'd0);
    check_eq("rst_rdata", resp_rdata,          32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", {31'd0, req_ready},  32'd1);

    preload(32'h100, 32'hDEADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, rd, er, cycs);
    check_eq("wload_lat",   lat,    32'd3);
    check_eq("wload_rdata", rd,     32'hDEADBEEF);
    check_eq("wload_err",   {31'd0, er}, 32'd0);
    check_eq("wload_adr",   rd_adr, 32'h100);

    preload(32'h100, 32'h80FF1234);
    do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, lat, rd, er, cycs);
    check_eq("lb_lat",   lat, 32'd3);
    check_eq("lb_rdata", rd,  32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, lat, rd, er, cycs);
    check_eq("lbu_rdata", rd, 32'h00000080);
    do_req(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, lat, rd, er, cycs);
    check_eq("lh_rdata", rd, 32'hFFFF80FF);
    do_req(1'b0, 2'd1, 1'b1, 32'h100, 32'h0, lat, rd, er, cycs);
    check_eq("lhu_rdata", rd, 32'h00001234);

    preload(32'h200, 32'h11223344);
    do_req(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, lat, rd, er, cycs);
    check_eq("sh_lat",    lat,    32'd6);
    check_eq("sh_rd_adr", rd_adr, 32'h200);
    check_eq("sh_wr_adr", wr_adr, 32'h200);
    check_eq("sh_wr_dat", wr_dat, 32'hABCD3344);
    check_eq("sh_cycs",   cycs,   32'd4);
    check_eq("sh_err",    {31'd0, er}, 32'd0);
    check_eq("sh_rdata",  rd,     32'd0);
    check_eq("sh_mem",    mem[8'h80], 32'hABCD3344);

    do_req(1'b1, 2'd0, 1'b0, 32'h201, 32'hFFFFFF5A, lat, rd, er, cycs);
    check_eq("sb_lat", lat,        32'd6);
    check_eq("sb_mem", mem[8'h80], 32'hABCD5A44);

    do_req(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, lat, rd, er, cycs);
    check_eq("mis_w_lat",   lat,  32'd1);
    check_eq("mis_w_err",   {31'd0, er}, 32'd1);
    check_eq("mis_w_rdata", rd,   32'd0);
    check_eq("mis_w_cycs",  cycs, 32'd0);
    do_req(1'b1, 2'd1, 1'b0, 32'h203, 32'h1234, lat, rd, er, cycs);
    check_eq("mis_h_err",  {31'd0, er}, 32'd1);
    check_eq("mis_h_cycs", cycs, 32'd0);
    do_req(1'b0, 2'd3, 1'b0, 32'h200, 32'h0, lat, rd, er, cycs);
    check_eq("ill_sz_err", {31'd0, er}, 32'd1);
    check_eq("ill_sz_lat", lat, 32'd1);

    do_req(1'b1, 2'd2, 1'b0, 32'h300, 32'h12345678, lat, rd, er, cycs);
    check_eq("sw_lat", lat, 32'd3);
    check_eq("sw_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, lat, rd, er, cycs);
    check_eq("b2b_lat",   lat, 32'd3);
    check_eq("b2b_rdata", rd,  32'h12345678);

    // Reset while the WRITE cycle is on the bus.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h380; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("pre_rst_we", {31'd0, wb_we}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_cyc", {31'd0, wb_cyc}, 32'd0);
    check_eq("mid_rst_stb", {31'd0, wb_stb}, 32'd0);
    check_eq("mid_rst_we",  {31'd0, wb_we},  32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);

    do_req(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, lat, rd, er, cycs);
    check_eq("recov_rdata", rd,  32'h12345678);
    check_eq("recov_lat",   lat, 32'd3);

`ifdef LSU_TIMEOUT_EN
    silent = 1'b1;
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, rd, er, cycs);
    check_eq("tmo_lat",   lat, 32'd17);
    check_eq("tmo_err",   {31'd0, er}, 32'd1);
    check_eq("tmo_rdata", rd,  32'd0);
    silent = 1'b0;
`endif

    repeat (4) @(negedge clk);
    check_eq("resp_count", resp_cnt, exp_resp);
    check_eq("cyc_after_ack", viol, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
